// File: rtl/ysyx_22050550_sram_axi_slave.sv
// Flop-array AXI-style memory responder with independent read/write FSMs and INCR bursts.
// Define YSYX_22050550_SRAM_DELAY_EN to insert LATENCY wait cycles before the first read beat.
module ysyx_22050550_sram_axi_slave #(
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ar_valid,
  output logic        io_ar_ready,
  input  logic [63:0] io_ar_bits_addr,
  input  logic [7:0]  io_ar_bits_len,
  output logic        io_r_valid,
  input  logic        io_r_ready,
  output logic [63:0] io_r_bits_data,
  output logic        io_r_bits_last,
  input  logic        io_aw_valid,
  output logic        io_aw_ready,
  input  logic [63:0] io_aw_bits_addr,
  input  logic [7:0]  io_aw_bits_len,
  input  logic        io_w_valid,
  output logic        io_w_ready,
  input  logic [63:0] io_w_bits_data,
  input  logic [7:0]  io_w_bits_strb,
  output logic        io_b_valid,
  input  logic        io_b_ready,
  output logic [1:0]  io_b_bits_resp
);
  localparam int DATA_W = 64;
  localparam int AW     = $clog2(DEPTH);

`ifdef YSYX_22050550_SRAM_DELAY_EN
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
`else
  typedef enum logic [1:0] {R_IDLE, R_DATA} rstate_t;
`endif
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  logic [DATA_W-1:0] mem [DEPTH];

  rstate_t       rstate;
  logic [AW-1:0] raddr;
  logic [7:0]    rcnt;
  wstate_t       wstate;
  logic [AW-1:0] waddr;
  logic [7:0]    wcnt;

  logic [63:0] ar_off;
  logic [63:0] aw_off;
  logic        ar_hs;
  logic        r_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;

  // Out-of-range addresses alias: only the word-index bits of the offset are kept.
  assign ar_off = io_ar_bits_addr - BASE;
  assign aw_off = io_aw_bits_addr - BASE;

  assign io_ar_ready    = (rstate == R_IDLE);
  assign io_r_valid     = (rstate == R_DATA);
  assign io_r_bits_last = io_r_valid && (rcnt == 8'd0);
  assign io_r_bits_data = io_r_valid ? mem[raddr] : '0;
  assign io_aw_ready    = (wstate == W_IDLE);
  assign io_w_ready     = (wstate == W_DATA);
  assign io_b_valid     = (wstate == W_RESP);
  assign io_b_bits_resp = 2'b00;

  assign ar_hs = io_ar_valid & io_ar_ready;
  assign r_hs  = io_r_valid  & io_r_ready;
  assign aw_hs = io_aw_valid & io_aw_ready;
  assign w_hs  = io_w_valid  & io_w_ready;
  assign b_hs  = io_b_valid  & io_b_ready;

`ifdef YSYX_22050550_SRAM_DELAY_EN
  logic [7:0] dly_cnt;
`else
  logic [31:0] unused_latency;
  assign unused_latency = LATENCY;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ar_off[63:AW+3], ar_off[2:0], aw_off[63:AW+3], aw_off[2:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rstate  <= R_IDLE;
      raddr   <= '0;
      rcnt    <= '0;
`ifdef YSYX_22050550_SRAM_DELAY_EN
      dly_cnt <= '0;
`endif
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            raddr <= ar_off[AW+2:3];
            rcnt  <= io_ar_bits_len;
`ifdef YSYX_22050550_SRAM_DELAY_EN
            dly_cnt <= 8'(LATENCY);
            rstate  <= R_WAIT;
`else
            rstate  <= R_DATA;
`endif
          end
        end
`ifdef YSYX_22050550_SRAM_DELAY_EN
        R_WAIT: begin
          if (dly_cnt <= 8'd1) rstate <= R_DATA;
          else                 dly_cnt <= dly_cnt - 8'd1;
        end
`endif
        R_DATA: begin
          if (r_hs) begin
            raddr <= raddr + AW'(1);
            rcnt  <= rcnt - 8'd1;
            if (rcnt == 8'd0) rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wstate <= W_IDLE;
      waddr  <= '0;
      wcnt   <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            waddr  <= aw_off[AW+2:3];
            wcnt   <= io_aw_bits_len;
            wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            waddr <= waddr + AW'(1);
            wcnt  <= wcnt - 8'd1;
            if (wcnt == 8'd0) wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_hs) wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Array is never reset; a read in the same cycle as a write sees the old word.
  always_ff @(posedge clock) begin
    if (w_hs) begin
      for (int i = 0; i < 8; i++) begin
        if (io_w_bits_strb[i]) mem[waddr][8*i +: 8] <= io_w_bits_data[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/ysyx_22050550_sram_axi_slave.md
# ysyx_22050550_sram_axi_slave

AXI-style memory responder that terminates the `io_sram_Axi_*` port of the IFU/LSU arbiter. It holds a flop-based 64-bit word array and serves single or INCR-burst reads and writes with independent read and write state machines. An optional per-read latency counter emulates slow memory for stall testing.

## Interface
Parameters:
- DEPTH, 1024, number of 64-bit words; must be a power of 2.
- BASE, 64'h8000_0000, byte address mapped to word 0.
- LATENCY, 4, extra wait cycles before the first read beat; used only with the delay macro.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_ar_valid / io_ar_ready  in/out  1/1  read-address handshake.
- io_ar_bits_addr  in  64  read byte address; bits [2:0] ignored.
- io_ar_bits_len  in  8  beats minus 1; tie to 0 for single beat.
- io_r_valid / io_r_ready  out/in  1/1  read-data handshake.
- io_r_bits_data  out  64  read data.
- io_r_bits_last  out  1  final beat of the burst.
- io_aw_valid / io_aw_ready  in/out  1/1  write-address handshake.
- io_aw_bits_addr  in  64  write byte address.
- io_aw_bits_len  in  8  beats minus 1.
- io_w_valid / io_w_ready  in/out  1/1  write-data handshake.
- io_w_bits_data  in  64  write data.
- io_w_bits_strb  in  8  byte enables; bit i writes byte i.
- io_b_valid / io_b_ready  out/in  1/1  write-response handshake.
- io_b_bits_resp  out  2  constant 2'b00 (OKAY).

## Operation
Word index:
- Index = (addr - BASE)[log2(DEPTH)+2:3].
- Out-of-range addresses alias modulo DEPTH. No error response is generated.

Read FSM (R_IDLE, R_WAIT, R_DATA):
- R_IDLE: io_ar_ready = 1. On an ar handshake, latch the index into raddr and the len into rcnt. Go to R_DATA, or to R_WAIT when the delay macro is enabled.
- R_WAIT: count LATENCY cycles, then go to R_DATA. io_ar_ready = 0.
- R_DATA: io_r_valid = 1 and io_r_bits_data = mem[raddr], read combinationally from the array.
  - io_r_bits_last = (rcnt == 0).
  - On an r handshake: raddr increments, wrapping at DEPTH, and rcnt decrements.
  - A handshake on the last beat returns the FSM to R_IDLE.
- io_r_bits_data is 0 whenever io_r_valid = 0.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: io_aw_ready = 1. On an aw handshake, latch waddr and wcnt, then go to W_DATA. io_w_ready stays 0 in W_IDLE even if io_w_valid is high; the master holds W.
- W_DATA: io_w_ready = 1.
  - Each w handshake writes the strobed bytes of mem[waddr] at that edge, then increments waddr and decrements wcnt.
  - The handshake at wcnt == 0 moves the FSM to W_RESP.
- W_RESP: io_b_valid = 1. A b handshake returns the FSM to W_IDLE.

Concurrency and reset:
- The read and write FSMs are fully independent. Both may be active in the same cycle.
- Same-word collision: a read beat presented in the write cycle returns the old data. The new data is visible from the next cycle.
- Reset, including mid-burst: both FSMs return to IDLE and all counters clear. Memory contents are not reset.
- Output values during reset:
  - io_ar_ready = 1, io_aw_ready = 1.
  - io_r_valid, io_r_bits_last, io_w_ready and io_b_valid = 0.
  - io_r_bits_data = 0, io_b_bits_resp = 0.

## Timing
- Read latency: an ar handshake in cycle N gives io_r_valid in cycle N+1, or N+1+LATENCY when the delay macro is enabled.
- Read bursts: beats stream one per cycle while io_r_ready stays high. io_r_valid/data/last hold stable while io_r_ready is low.
- io_ar_ready reasserts the cycle after the last-beat handshake, giving a minimum of 2 cycles between single-beat reads without delay.
- Write timing: an aw handshake in cycle N gives io_w_ready from N+1. A last w handshake in cycle M gives io_b_valid at M+1. io_aw_ready returns the cycle after the b handshake.
- len = 255 is legal: 256 beats, with the address wrapping at DEPTH.

## Configuration
- YSYX_22050550_SRAM_DELAY_EN defined: R_WAIT is used, with an 8-bit down-counter loaded with LATENCY on the ar handshake. LATENCY = 0 behaves as undefined.
- Not defined: R_WAIT and the counter are not compiled, and ar goes directly to R_DATA.

## Test plan
- Reset then single write: aw addr 0x8000_0010, len 0; w data 0x1122334455667788, strb 0xFF. Required: io_b_valid exactly 1 cycle after the w handshake, and mem[2] = 0x1122334455667788.
- Single read of 0x8000_0010, len 0, with io_r_ready held high. Required: io_r_valid and io_r_bits_last at N+1 with data 0x1122334455667788, and io_ar_ready high at N+2.
- Partial strobe: write 0xAAAA... with strb 0x0F to the same word. A readback returns 0x11223344AAAAAAAA.
- Burst read with len 3 from 0x8000_0000, with io_r_ready toggled 1,0,1,1,1. Required: 4 beats mem[0..3] in order, data held during the stall, and last asserted only on beat 4.
- Simultaneous events: a write to word 5 and a read of word 5 handshake in the same cycle. The read returns the old value, and a following read returns the new value. Assert reset during beat 2 of a len-3 read: outputs go to reset values immediately, and io_ar_ready = 1 after reset is released.
- With YSYX_22050550_SRAM_DELAY_EN and LATENCY = 4: an ar handshake in cycle N gives the first io_r_valid at N+5, and io_ar_ready stays 0 during N+1..N+4.
